// File: rtl/regador_pkg.sv
// +----------------------------------------------------------------------+
// | regador_pkg                                                           |
// | Shared types and helpers for the irrigation scheduler.                |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package regador_pkg;

  localparam int N_PLANTAS = 3;

  typedef logic [1:0] planta_t;
  typedef logic [3:0] periodo_t;

  localparam planta_t PLANTA_NENHUMA = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REGANDO = 2'd1,
    PAUSA   = 2'd2
  } estado_t;

  // Lowest-index set bit wins; PLANTA_NENHUMA when nothing is pending.
  function automatic planta_t menor_pendente(input logic [N_PLANTAS-1:0] p);
    planta_t k;
    k = PLANTA_NENHUMA;
    for (int i = N_PLANTAS - 1; i >= 0; i--) begin
      if (p[i]) k = planta_t'(i);
    end
    return k;
  endfunction

  // One-hot mask for a plant index; all-zero for PLANTA_NENHUMA.
  function automatic logic [N_PLANTAS-1:0] um_quente(input planta_t k);
    logic [N_PLANTAS-1:0] v;
    v = '0;
    for (int i = 0; i < N_PLANTAS; i++) begin
      if (k == planta_t'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_tempo.sv
// +----------------------------------------------------------------------+
// | divisor_tempo                                                         |
// | Free-running prescaler and seconds-of-day counter producing           |
// | one-cycle seg_tick / dia_tick strobes.                                |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module divisor_tempo #(
  parameter int CLK_HZ      = 60,
  parameter int SEG_POR_DIA = 86400
) (
  input  logic clk,
  input  logic rst,
  output logic seg_tick_o,
  output logic dia_tick_o
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (SEG_POR_DIA > 1) ? $clog2(SEG_POR_DIA) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SEG_MAX   = SW'(SEG_POR_DIA - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] seg_q, seg_d;

  // Strobes are decoded from the current count so they line up with the wrap.
  assign seg_tick_o = (presc_q == PRESC_MAX);
  assign dia_tick_o = seg_tick_o && (seg_q == SEG_MAX);

  // Next count: prescaler wraps every second, seconds wrap every day.
  always_comb begin
    presc_d = seg_tick_o ? '0 : presc_q + PW'(1);
    seg_d   = seg_q;
    if (seg_tick_o) begin
      seg_d = (seg_q == SEG_MAX) ? '0 : seg_q + SW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      seg_q   <= '0;
    end else begin
      presc_q <= presc_d;
      seg_q   <= seg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/agendador_rega.sv
// +----------------------------------------------------------------------+
// | agendador_rega                                                        |
// | Irrigation scheduler: per-plant day periods, manual requests and a    |
// | one-pump-at-a-time watering sequencer with pressure-recovery pause.   |
// | Optional: REGA_SENSOR_UMIDADE_EN adds umido/pulado soil-wet skipping. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module agendador_rega
  import regador_pkg::*;
#(
  parameter int CLK_HZ      = 60,
  parameter int SEG_POR_DIA = 86400,
  parameter int REGA_SEG    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_planta,
  input  logic [3:0] cfg_periodo,
  input  logic [2:0] rega_manual,
`ifdef REGA_SENSOR_UMIDADE_EN
  input  logic [2:0] umido,
  output logic [2:0] pulado,
`endif
  output logic       pump1,
  output logic       pump2,
  output logic       pump3,
  output logic [2:0] pendente,
  output logic [1:0] ativa
);

  localparam logic [7:0] DUR_INI = 8'(REGA_SEG);

  logic w_seg_tick;
  logic w_dia_tick;

  divisor_tempo #(
    .CLK_HZ      (CLK_HZ),
    .SEG_POR_DIA (SEG_POR_DIA)
  ) u_divisor (
    .clk        (clk),
    .rst        (rst),
    .seg_tick_o (w_seg_tick),
    .dia_tick_o (w_dia_tick)
  );

  estado_t    estado_q, estado_d;
  planta_t    ativa_q, ativa_d;
  logic [7:0] dur_q, dur_d;
  logic [2:0] pump_q, pump_d;
  logic [2:0] pendente_q, pendente_d;
  periodo_t   periodo_q [N_PLANTAS];
  periodo_t   periodo_d [N_PLANTAS];
  periodo_t   dia_cnt_q [N_PLANTAS];
  periodo_t   dia_cnt_d [N_PLANTAS];
`ifdef REGA_SENSOR_UMIDADE_EN
  logic [2:0] pulado_q, pulado_d;
`endif

  logic [2:0] w_limpa;
  planta_t    w_sel;
  logic       w_pular;
  logic       w_cfg_aceito;

  // Configuration is refused only while a pump is running.
  assign cfg_ready    = (estado_q != REGANDO);
  assign w_cfg_aceito = cfg_valid && cfg_ready;
  assign w_sel        = menor_pendente(pendente_q);

`ifdef REGA_SENSOR_UMIDADE_EN
  assign w_pular = |(umido & um_quente(w_sel));
  assign pulado  = pulado_q;
`else
  assign w_pular = 1'b0;
`endif

  // Sequencer next state: select, water for DUR_INI seconds, then pause one tick.
  always_comb begin
    estado_d = estado_q;
    ativa_d  = ativa_q;
    dur_d    = dur_q;
    pump_d   = pump_q;
    w_limpa  = '0;
`ifdef REGA_SENSOR_UMIDADE_EN
    pulado_d = '0;
`endif
    case (estado_q)
      IDLE: begin
        if (pendente_q != '0) begin
          w_limpa = um_quente(w_sel);
          if (w_pular) begin
`ifdef REGA_SENSOR_UMIDADE_EN
            pulado_d = um_quente(w_sel);
`endif
          end else begin
            ativa_d  = w_sel;
            dur_d    = DUR_INI;
            pump_d   = um_quente(w_sel);
            estado_d = REGANDO;
          end
        end
      end
      REGANDO: begin
        if (w_seg_tick) begin
          if (dur_q <= 8'd1) begin
            dur_d    = '0;
            pump_d   = '0;
            ativa_d  = PLANTA_NENHUMA;
            estado_d = PAUSA;
          end else begin
            dur_d = dur_q - 8'd1;
          end
        end
      end
      PAUSA: begin
        if (w_seg_tick) estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
        pump_d   = '0;
        ativa_d  = PLANTA_NENHUMA;
      end
    endcase
  end

  // Per-plant day counting and request flags; new requests beat the
  // selection clear, and an accepted configuration beats everything.
  always_comb begin
    pendente_d = (pendente_q & ~w_limpa) | rega_manual;
    for (int i = 0; i < N_PLANTAS; i++) begin
      periodo_d[i] = periodo_q[i];
      dia_cnt_d[i] = dia_cnt_q[i];
      if (w_cfg_aceito && (cfg_planta == planta_t'(i))) begin
        periodo_d[i]  = cfg_periodo;
        dia_cnt_d[i]  = '0;
        pendente_d[i] = 1'b0;
      end else if (w_dia_tick && (periodo_q[i] != '0)) begin
        if (dia_cnt_q[i] == (periodo_q[i] - 4'd1)) begin
          dia_cnt_d[i]  = '0;
          pendente_d[i] = 1'b1;
        end else begin
          dia_cnt_d[i] = dia_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
      ativa_q  <= PLANTA_NENHUMA;
      dur_q    <= '0;
      pump_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ativa_q  <= ativa_d;
      dur_q    <= dur_d;
      pump_q   <= pump_d;
    end
  end

  // Plant configuration, day counter and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PLANTAS; i++) begin
        periodo_q[i] <= '0;
        dia_cnt_q[i] <= '0;
      end
      pendente_q <= '0;
    end else begin
      for (int i = 0; i < N_PLANTAS; i++) begin
        periodo_q[i] <= periodo_d[i];
        dia_cnt_q[i] <= dia_cnt_d[i];
      end
      pendente_q <= pendente_d;
    end
  end

`ifdef REGA_SENSOR_UMIDADE_EN
  // Skip strobe register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulado_q <= '0;
    else     pulado_q <= pulado_d;
  end
`endif

  assign pump1    = pump_q[0];
  assign pump2    = pump_q[1];
  assign pump3    = pump_q[2];
  assign pendente = pendente_q;
  assign ativa    = ativa_q;

endmodule

`default_nettype wire

// File: tb/tb_agendador_rega.sv
// +----------------------------------------------------------------------+
// | tb_agendador_rega                                                     |
// | Directed + random bench for agendador_rega with a timing-based model. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_agendador_rega;

  localparam int C   = 4;
  localparam int S   = 8;
  localparam int R   = 2;
  localparam int DIA = C * S;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_planta = 2'd0;
  logic [3:0] cfg_periodo = 4'd0;
  logic [2:0] rega_manual = 3'd0;
  logic       cfg_ready, pump1, pump2, pump3;
  logic [2:0] pendente;
  logic [1:0] ativa;

  agendador_rega #(.CLK_HZ(C), .SEG_POR_DIA(S), .REGA_SEG(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_planta  (cfg_planta),
    .cfg_periodo (cfg_periodo),
    .rega_manual (rega_manual),
    .pump1       (pump1),
    .pump2       (pump2),
    .pump3       (pump3),
    .pendente    (pendente),
    .ativa       (ativa)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edge index since reset release and absolute edge
  // times of the current watering slot.
  int         e, e_sel, off_edge, busy_until, act_k;
  int         per_m [3];
  int         dias_m [3];
  logic [2:0] pend_m;

  // Observed activity log.
  int         on_run, off_run;
  logic [2:0] p_prev;
  logic [1:0] ativa_prev;
  int         q_on [$];
  int         q_gap [$];
  logic [2:0] q_quem [$];
  logic [1:0] q_ativa [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic limpa_log();
    q_on.delete(); q_gap.delete(); q_quem.delete(); q_ativa.delete();
  endtask

  task automatic model_reset();
    e = 0; e_sel = -100; off_edge = -100; busy_until = -100; act_k = 3;
    for (int i = 0; i < 3; i++) begin per_m[i] = 0; dias_m[i] = 0; end
    pend_m = 3'b000;
    on_run = 0; off_run = 0; p_prev = 3'b000; ativa_prev = 2'd3;
  endtask

  // Apply the inputs present at edge e to the model.
  task automatic model_edge();
    bit dia, pronto;
    logic [2:0] clr, np;
    int k, prox;
    dia    = (e % DIA) == DIA - 1;
    pronto = !(e_sel < e && e <= off_edge);
    clr    = 3'b000;
    if (e > busy_until && pend_m != 3'b000) begin
      k = pend_m[0] ? 0 : (pend_m[1] ? 1 : 2);
      clr[k] = 1'b1;
      act_k  = k;
      e_sel  = e;
      prox   = e + 1;
      while (prox % C != C - 1) prox++;
      off_edge   = prox + (R - 1) * C;
      busy_until = off_edge + C;
    end
    np = (pend_m & ~clr) | rega_manual;
    for (int i = 0; i < 3; i++) begin
      if (cfg_valid && pronto && cfg_planta == 2'(i)) begin
        per_m[i] = int'(cfg_periodo); dias_m[i] = 0; np[i] = 1'b0;
      end else if (dia && per_m[i] != 0) begin
        dias_m[i]++;
        if (dias_m[i] % per_m[i] == 0) np[i] = 1'b1;
      end
    end
    pend_m = np;
    e++;
  endtask

  task automatic verifica();
    int x;
    logic reg_b;
    logic [2:0] pe;
    x     = e - 1;
    reg_b = (e_sel <= x && x < off_edge);
    pe    = reg_b ? (3'b001 << act_k) : 3'b000;
    chk("pumps", {29'd0, pump3, pump2, pump1}, {29'd0, pe});
    chk("pendente", {29'd0, pendente}, {29'd0, pend_m});
    chk("ativa", {30'd0, ativa}, reg_b ? act_k : 3);
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !reg_b});
    chk("onehot", {31'd0, ($countones({pump3, pump2, pump1}) <= 1)}, 32'd1);
  endtask

  task automatic step();
    logic [2:0] p;
    @(posedge clk);
    model_edge();
    #1;
    verifica();
    p = {pump3, pump2, pump1};
    if (p != 3'b000) begin
      if (p_prev == 3'b000) begin q_gap.push_back(off_run); q_quem.push_back(p); end
      on_run++; off_run = 0;
    end else begin
      if (p_prev != 3'b000) q_on.push_back(on_run);
      on_run = 0; off_run++;
    end
    if (ativa != ativa_prev) q_ativa.push_back(ativa);
    p_prev = p; ativa_prev = ativa;
  endtask

  task automatic escreve_cfg(input int p, input int per);
    int guard;
    guard = 0;
    cfg_valid = 1'b1; cfg_planta = 2'(p); cfg_periodo = 4'(per);
    while (!cfg_ready && guard < 100) begin step(); guard++; end
    chk("cfg_timeout", {31'd0, guard < 100}, 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic alinha_dia();
    while (e % DIA != 0) step();
  endtask

  task automatic checa_reset(input string tag);
    chk({tag, "_pumps"}, {29'd0, pump3, pump2, pump1}, 32'd0);
    chk({tag, "_pendente"}, {29'd0, pendente}, 32'd0);
    chk({tag, "_ativa"}, {30'd0, ativa}, 32'd3);
    chk({tag, "_ready"}, {31'd0, cfg_ready}, 32'd1);
  endtask

  task automatic checa_duracoes(input string tag);
    foreach (q_on[i]) begin
      chk({tag, "_on_ok"}, {31'd0, (q_on[i] >= R*C-(C-1) && q_on[i] <= R*C+(C-1))}, 32'd1);
    end
  endtask

  initial begin
    int espera;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checa_reset("rst_ini");
    @(negedge clk) rst = 1'b0;

    // Start a watering, then assert reset in the middle of it.
    rega_manual = 3'b010; step(); rega_manual = 3'b000;
    repeat (6) step();
    chk("pump2_antes_rst", {31'd0, pump2}, 32'd1);
    #2 rst = 1'b1;
    #1 checa_reset("rst_meio");
    model_reset(); limpa_log();
    @(negedge clk) rst = 1'b0;
    repeat (40) step();
    chk("sem_rega_pos_rst", q_quem.size(), 32'd0);

    // Plant 0 every day.
    alinha_dia();
    escreve_cfg(0, 1);
    limpa_log();
    repeat (3 * DIA + 14) step();
    chk("p0_qtd", q_quem.size(), 32'd3);
    foreach (q_quem[i]) chk("p0_quem", {29'd0, q_quem[i]}, 32'd1);
    checa_duracoes("p0");

    // Plant 1 every two days, plant 0 off.
    escreve_cfg(0, 0);
    alinha_dia();
    escreve_cfg(1, 2);
    limpa_log();
    repeat (4 * DIA + 14) step();
    chk("p1_qtd", q_quem.size(), 32'd2);
    foreach (q_quem[i]) chk("p1_quem", {29'd0, q_quem[i]}, 32'd2);

    // Arbitration of simultaneous manual requests.
    escreve_cfg(1, 0);
    limpa_log();
    rega_manual = 3'b101; step(); rega_manual = 3'b000;
    repeat (40) step();
    chk("arb_qtd", q_quem.size(), 32'd2);
    if (q_quem.size() == 2) begin
      chk("arb_primeira", {29'd0, q_quem[0]}, 32'd1);
      chk("arb_segunda", {29'd0, q_quem[1]}, 32'd4);
      chk("arb_pausa", {31'd0, (q_gap[1] >= C && q_gap[1] <= C + 1)}, 32'd1);
    end
    chk("arb_ativa_qtd", q_ativa.size(), 32'd4);
    if (q_ativa.size() == 4) begin
      chk("arb_ativa0", {30'd0, q_ativa[0]}, 32'd0);
      chk("arb_ativa1", {30'd0, q_ativa[1]}, 32'd3);
      chk("arb_ativa2", {30'd0, q_ativa[2]}, 32'd2);
      chk("arb_ativa3", {30'd0, q_ativa[3]}, 32'd3);
    end
    checa_duracoes("arb");

    // Configuration held off while watering, accepted in the pause.
    rega_manual = 3'b001; step(); rega_manual = 3'b000;
    step();
    chk("hs_ready_regando", {31'd0, cfg_ready}, 32'd0);
    cfg_valid = 1'b1; cfg_planta = 2'd2; cfg_periodo = 4'd3;
    espera = 0;
    while (!cfg_ready && espera < 60) begin step(); espera++; end
    chk("hs_espera", {31'd0, (espera > 0 && espera < 60)}, 32'd1);
    chk("hs_ativa_pausa", {30'd0, ativa}, 32'd3);
    chk("hs_pumps_pausa", {29'd0, pump3, pump2, pump1}, 32'd0);
    step();
    cfg_valid = 1'b0;
    limpa_log();
    repeat (3 * DIA + 14) step();
    chk("hs_p2_qtd", q_quem.size(), 32'd1);
    foreach (q_quem[i]) chk("hs_p2_quem", {29'd0, q_quem[i]}, 32'd4);

    // Disable on the day-tick edge, then manual still waters.
    escreve_cfg(2, 0);
    repeat (12) step();
    escreve_cfg(0, 1);
    while (e % DIA != DIA - 1) step();
    cfg_valid = 1'b1; cfg_planta = 2'd0; cfg_periodo = 4'd0;
    chk("bd_ready", {31'd0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 1'b0;
    chk("bd_pendente0", {31'd0, pendente[0]}, 32'd0);
    limpa_log();
    repeat (DIA + 4) step();
    chk("bd_sem_rega", q_quem.size(), 32'd0);
    rega_manual = 3'b001; step(); rega_manual = 3'b000;
    repeat (20) step();
    chk("bd_manual_qtd", q_quem.size(), 32'd1);
    foreach (q_quem[i]) chk("bd_manual_quem", {29'd0, q_quem[i]}, 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      rega_manual = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cfg_valid   = ($urandom_range(0, 39) == 0);
      cfg_planta  = 2'($urandom_range(0, 3));
      cfg_periodo = 4'($urandom_range(0, 3));
      step();
    end
    rega_manual = 3'b000;
    cfg_valid   = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
